// File: rtl/mdu_ctrl_pkg.sv
// Shared op codes for the iterative multiply/divide sequencer.
// Latency: none (types and constants only).
// Backpressure: n/a.
package mdu_ctrl_pkg;

    // Three-bit M-extension op bus; bit 2 set means a divide-class op.
    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    localparam int MDU_OP_W = 3;

endpackage

// File: rtl/mdu_ctrl_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide trial subtract.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the result is stored.
module mdu_step #(
    parameter int DATA_W = 32
) (
    input  logic                  is_div,
    input  logic [2*DATA_W-1:0]   acc_i,
    input  logic [DATA_W-1:0]     opnd_i,
    output logic [2*DATA_W-1:0]   acc_o
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W-1:0] rem_sub;
    logic              ge;

    // Multiply: {hi,lo} holds partial product / remaining multiplier bits.
    // Divide: {hi,lo} holds partial remainder / remaining dividend then quotient bits.
    always_comb begin
        sum     = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh  = acc_i[2*DATA_W-1:DATA_W-1];
        ge      = rem_sh >= {1'b0, opnd_i};
        rem_sub = rem_sh[DATA_W-1:0] - opnd_i;
        if (!is_div) begin
            acc_o = {sum, acc_i[DATA_W-1:1]};
        end else if (ge) begin
            acc_o = {rem_sub, acc_i[DATA_W-2:0], 1'b1};
        end else begin
            acc_o = {rem_sh[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// RV32M iterative multiply/divide sequencer sitting beside EX.
// Latency: DATA_W+1 cycles start-to-ready, 1 cycle on the fast paths.
// Backpressure: stall_req_o holds the pipeline while an op is captured or computing.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic              annul_i,
    output logic [DATA_W-1:0] result_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              stall_req_o
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state;
    mdu_op_e             op_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [DATA_W-1:0]   opnd_q;
    logic                neg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   result_q;

    mdu_op_e             op_e;
    logic                s1, s2, cap_neg, fast;
    logic [DATA_W-1:0]   mag1, mag2, fast_val;
    logic [2*DATA_W-1:0] acc_step, prod;
    logic [DATA_W-1:0]   quo, rem, final_res;

    mdu_step #(.DATA_W(DATA_W)) u_step (
        .is_div (op_q[2]),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_step)
    );

    // Operand capture: strip signs into magnitudes and spot the one-cycle cases.
    always_comb begin
        op_e     = mdu_op_e'(op_i);
        s1       = op1_i[DATA_W-1] & (op_e inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
        s2       = op2_i[DATA_W-1] & (op_e inside {MDU_MULH, MDU_DIV, MDU_REM});
        mag1     = s1 ? -op1_i : op1_i;
        mag2     = s2 ? -op2_i : op2_i;
        cap_neg  = (op_e == MDU_REM) ? s1 : (s1 ^ s2);
        fast     = 1'b0;
        fast_val = '0;
        if (op_i[2] && op2_i == '0) begin
            fast     = 1'b1;
            fast_val = op_i[1] ? op1_i : '1;
        end else if (op_e inside {MDU_DIV, MDU_REM} && op1_i == {1'b1, {(DATA_W-1){1'b0}}}
                     && op2_i == '1) begin
            fast     = 1'b1;
            fast_val = (op_e == MDU_DIV) ? op1_i : '0;
        end else if (ZERO_SKIP && !op_i[2] && (op1_i == '0 || op2_i == '0)) begin
            fast     = 1'b1;
            fast_val = '0;
        end
    end

    // Final step: apply the single sign fix-up and pick the requested word.
    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        quo  = neg_q ? -acc_step[DATA_W-1:0] : acc_step[DATA_W-1:0];
        rem  = neg_q ? -acc_step[2*DATA_W-1:DATA_W] : acc_step[2*DATA_W-1:DATA_W];
        case (op_q)
            MDU_MUL:                       final_res = prod[DATA_W-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = prod[2*DATA_W-1:DATA_W];
            MDU_DIV, MDU_DIVU:             final_res = quo;
            default:                       final_res = rem;
        endcase
    end

    // Sequencer: capture in IDLE, iterate in CALC, strobe in DONE; annul always wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= MDU_MUL;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (annul_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_q  <= op_e;
                        neg_q <= cap_neg;
                        cnt_q <= '0;
                        if (op_i[2]) begin
                            acc_q  <= {{DATA_W{1'b0}}, mag1};
                            opnd_q <= mag2;
                        end else begin
                            acc_q  <= {{DATA_W{1'b0}}, mag2};
                            opnd_q <= mag1;
                        end
                        if (fast) begin
                            result_q <= fast_val;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W-1)) begin
                        result_q <= final_res;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign result_o    = result_q;
    assign ready_o     = (state == DONE) & ~annul_i;
    assign busy_o      = (state != IDLE);
    assign stall_req_o = rst & ~annul_i & (((state == IDLE) & start_i) | (state == CALC));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for the multiply/divide sequencer.
// Latency: checks 33-cycle normal and 1-cycle fast completion.
// Backpressure: counts stall_req_o cycles per op.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic        annul_i = 1'b0;
    logic [31:0] result_o;
    logic        ready_o, busy_o, stall_req_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_res = '0;

    mdu_ctrl #(.DATA_W(32), .ZERO_SKIP(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .stall_req_o (stall_req_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M results from plain wide arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic [31:0] r;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ea  = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb  = (op == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = ea * eb;
        case (op)
            3'd0:    r = p[31:0];
            3'd1, 3'd2, 3'd3: r = p[63:32];
            3'd4:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5:    r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    r = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic fast;
        fast = (op[2] && b == 0)
            || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            || (!op[2] && (a == 0 || b == 0));
        return fast ? 1 : 33;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        int exp_lat, cyc, stalls;
        exp_res = model(op, a, b);
        exp_lat = model_lat(op, a, b);
        @(negedge clk);
        start_i = 1'b1; op_i = op; op1_i = a; op2_i = b;
        cyc = 0; stalls = 0;
        #1;
        while (ready_o !== 1'b1 && cyc < 100) begin
            if (stall_req_o === 1'b1) stalls++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " ready"}, 32'(ready_o), 32'd1);
        chk({tag, " result"}, result_o, exp_res);
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " stalls"}, stalls, exp_lat);
        chk({tag, " done_stall"}, 32'(stall_req_o), 32'd0);
        last_res = exp_res;
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, " ready_pulse"}, 32'(ready_o), 32'd0);
        chk({tag, " busy_after"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [31:0] pool [5];
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        // Reset state
        #12;
        chk("rst result", result_o, 32'd0);
        chk("rst ready", 32'(ready_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst stall", 32'(stall_req_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed normal ops
        run_op("mul_7x6", MDU_MUL, 32'd7, 32'd6);
        chk("mul_7x6 value", last_res, 32'd42);
        run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", MDU_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7);
        run_op("remu_100_7", MDU_REMU, 32'd100, 32'd7);

        // Fast paths
        run_op("divu_by0", MDU_DIVU, 32'd100, 32'd0);
        run_op("rem_by0", MDU_REM, 32'd5, 32'd0);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mul_zero", MDU_MUL, 32'd0, 32'd123);

        // High-word multiplies
        run_op("mulh_min", MDU_MULH, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhu_max", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_m1_2", MDU_MULHSU, 32'hFFFF_FFFF, 32'd2);

        // Annul mid-CALC
        @(negedge clk);
        start_i = 1'b1; op_i = MDU_MUL; op1_i = 32'd1234; op2_i = 32'd5678;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        #1;
        chk("annul stall", 32'(stall_req_o), 32'd0);
        chk("annul ready", 32'(ready_o), 32'd0);
        @(posedge clk); #1;
        chk("annul busy", 32'(busy_o), 32'd0);
        chk("annul ready_after", 32'(ready_o), 32'd0);
        chk("annul result_hold", result_o, last_res);
        @(negedge clk);
        annul_i = 1'b0;
        run_op("divu_9_3", MDU_DIVU, 32'd9, 32'd3);

        // Annul in DONE suppresses the strobe
        @(negedge clk);
        start_i = 1'b1; op_i = MDU_DIVU; op1_i = 32'd1; op2_i = 32'd0;
        @(posedge clk); #1;
        chk("done busy", 32'(busy_o), 32'd1);
        annul_i = 1'b1;
        #1;
        chk("done annul ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        chk("done annul busy", 32'(busy_o), 32'd0);

        // Async reset mid-CALC
        @(negedge clk);
        start_i = 1'b1; op_i = MDU_MUL; op1_i = 32'd5; op2_i = 32'd5;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst result", result_o, 32'd0);
        chk("arst ready", 32'(ready_o), 32'd0);
        chk("arst busy", 32'(busy_o), 32'd0);
        chk("arst stall", 32'(stall_req_o), 32'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op("mul_3x3", MDU_MUL, 32'd3, 32'd3);

        // Randomized ops against the model
        pool[0] = 32'd0; pool[1] = 32'h8000_0000; pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'd1; pool[4] = 32'd7;
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 28);
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
